hist_accum_ram: RTL and testbench

Parametrised histogram accumulator RAM: a streaming sample port increments one bin per clock through a 2-stage read-modify-write pipeline with same-bin forwarding, while an Avalon-MM slave reads, writes and clears bins. Successor to the fixed 64x32 dual-port histogram RAM. It moves the increment logic out of the host into hardware and adds saturation, overflow flagging and a hardware clear engine. It sits between the sample source (pixel/ADC stream) and the JTAG-to-Avalon master.

---
 rtl/hist_pkg.sv | 18 +
 rtl/hist_sdp_ram.sv | 41 ++++
 rtl/hist_accum_ram.sv | 175 +++++++++++++++++
 tb/tb_hist_accum_ram.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// Shared definitions for the histogram accumulator: clear-engine state encoding
// and the bin-count derivation used to size the RAM and the clear pointer.
package hist_pkg;

    typedef logic [1:0] clr_state_t;

    localparam clr_state_t ST_IDLE  = 2'd0;
    localparam clr_state_t ST_DRAIN = 2'd1;
    localparam clr_state_t ST_CLEAR = 2'd2;

    localparam int unsigned BYTE_W = 8;

    // Number of bins addressable with a bin index of the given width.
    function automatic int unsigned hist_depth(input int unsigned bin_w);
        return 32'd1 << bin_w;
    endfunction

endpackage

// File: rtl/hist_sdp_ram.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read port.
// A read to the address being written returns the old contents.
module hist_sdp_ram
    import hist_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_wbe,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = hist_depth(ADDR_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Lane-wise write; non-blocking update gives old-data read-during-write.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (i_wbe[b]) begin
                    r_mem[i_waddr][b*BYTE_W +: BYTE_W] <= i_wdata[b*BYTE_W +: BYTE_W];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/hist_accum_ram.sv
// Histogram accumulator: a sample stream increments one bin per clock through a
// two-stage read-modify-write pipeline; an Avalon-MM slave reads/writes/clears bins.
module hist_accum_ram
    import hist_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned BIN_W    = 6,
    parameter int unsigned SATURATE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_valid,
    input  logic [BIN_W-1:0]      sample_bin,
    output logic                  sample_ready,
    input  logic [BIN_W-1:0]      address,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic [DATA_W/8-1:0]   byteenable,
    output logic                  waitrequest,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    input  logic                  clear_start,
    output logic                  busy,
    output logic                  overflow
);

    localparam int unsigned DEPTH = hist_depth(BIN_W);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(DEPTH - 1);

    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic [BIN_W-1:0]  r_clr_ptr;

    logic              r_s1_valid;
    logic [BIN_W-1:0]  r_s1_bin;
    logic              r_fwd_valid;
    logic [BIN_W-1:0]  r_fwd_bin;
    logic [DATA_W-1:0] r_fwd_data;

    logic              r_rdv;
    logic              r_rd_fwd;
    logic [DATA_W-1:0] r_rd_fwd_data;
    logic              r_overflow;

    logic              w_idle;
    logic              w_host_acc;
    logic              w_sample_acc;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [DATA_W-1:0] w_ram_q;
    logic [DATA_W-1:0] w_base;
    logic              w_base_max;
    logic [DATA_W-1:0] w_new;

    logic              w_ram_we;
    logic [BIN_W-1:0]  w_ram_waddr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [BE_W-1:0]   w_ram_wbe;
    logic              w_ram_re;
    logic [BIN_W-1:0]  w_ram_raddr;

    // Handshakes: host accesses win over samples; writes also wait for S1 to retire.
    assign w_idle       = (r_state == ST_IDLE);
    assign w_host_acc   = chipselect & (read | write);
    assign sample_ready = w_idle & ~w_host_acc;
    assign w_sample_acc = sample_valid & sample_ready;
    assign busy         = ~w_idle;
    assign waitrequest  = ~w_idle | (write & r_s1_valid);
    assign w_wr_acc     = chipselect & write & ~waitrequest;
    assign w_rd_acc     = chipselect & read & ~write & ~waitrequest;

    // S1 increment, taking the previous S1 result when it hit the same bin.
    assign w_base     = (r_fwd_valid && (r_fwd_bin == r_s1_bin)) ? r_fwd_data : w_ram_q;
    assign w_base_max = &w_base;

    always_comb begin
        w_new = w_base + DATA_W'(1);
        if (w_base_max) begin
            w_new = (SATURATE != 0) ? w_base : '0;
        end
    end

    // Single write port: the clear engine, S1 and host writes never coincide.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = r_s1_bin;
        w_ram_wdata = w_new;
        w_ram_wbe   = '1;
        if (r_state == ST_CLEAR) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = r_clr_ptr;
            w_ram_wdata = '0;
        end else if (r_s1_valid) begin
            w_ram_we    = 1'b1;
        end else if (w_wr_acc) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = address;
            w_ram_wdata = writedata;
            w_ram_wbe   = byteenable;
        end
    end

    assign w_ram_re    = w_sample_acc | w_rd_acc;
    assign w_ram_raddr = w_rd_acc ? address : sample_bin;

    hist_sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (BIN_W),
        .BE_W   (BE_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_wbe   (w_ram_wbe),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_q)
    );

    // Clear engine next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (clear_start)             w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!r_s1_valid)             w_state_nxt = ST_CLEAR;
            ST_CLEAR: if (r_clr_ptr == LAST_BIN)   w_state_nxt = ST_IDLE;
            default:                               w_state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_CLEAR;
            r_clr_ptr     <= '0;
            r_s1_valid    <= 1'b0;
            r_s1_bin      <= '0;
            r_fwd_valid   <= 1'b0;
            r_fwd_bin     <= '0;
            r_fwd_data    <= '0;
            r_rdv         <= 1'b0;
            r_rd_fwd      <= 1'b0;
            r_rd_fwd_data <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Pointer wraps back to 0 on the last bin, ready for the next clear.
            if (r_state == ST_CLEAR) begin
                r_clr_ptr <= r_clr_ptr + BIN_W'(1);
            end
            r_s1_valid    <= w_sample_acc;
            r_s1_bin      <= sample_bin;
            r_fwd_valid   <= r_s1_valid;
            r_fwd_bin     <= r_s1_bin;
            r_fwd_data    <= w_new;
            r_rdv         <= w_rd_acc;
            r_rd_fwd      <= r_s1_valid && (r_s1_bin == address);
            r_rd_fwd_data <= w_new;
            if (r_state == ST_CLEAR) begin
                r_overflow <= 1'b0;
            end else if (r_s1_valid && w_base_max) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // RAM output register is the read stage; a same-cycle S1 write overrides it.
    assign readdata      = r_rdv ? (r_rd_fwd ? r_rd_fwd_data : w_ram_q) : '0;
    assign readdatavalid = r_rdv;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_hist_accum_ram.sv
// Scoreboard bench: a wide saturating instance plus two 8-bit instances
// (saturating and wrapping) sharing one stimulus bus.
module tb_hist_accum_ram;

    localparam int unsigned DEPTH = 64;

    typedef struct {
        logic [31:0] val;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        m_sv = 0, m_cs = 0, m_rd = 0, m_wr = 0, m_clr = 0;
    logic [5:0]  m_sbin = '0, m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_be = '0;
    logic        m_srdy, m_wait, m_rdv, m_busy, m_ovf;
    logic [31:0] m_rdata;

    logic        n_sv = 0, n_cs = 0, n_rd = 0, n_wr = 0, n_clr = 0;
    logic [5:0]  n_sbin = '0, n_addr = '0;
    logic [7:0]  n_wdata = '0;
    logic [0:0]  n_be = '0;
    logic        s_srdy, s_wait, s_rdv, s_busy, s_ovf;
    logic [7:0]  s_rdata;
    logic        w_srdy, w_wait, w_rdv, w_busy, w_ovf;
    logic [7:0]  w_rdata;

    exp_t q_m[$];
    exp_t q_s[$];
    exp_t q_w[$];
    int n_checks = 0;
    int n_fails  = 0;

    hist_accum_ram #(.DATA_W(32), .BIN_W(6), .SATURATE(1)) u_main (
        .clk(clk), .reset(reset), .sample_valid(m_sv), .sample_bin(m_sbin), .sample_ready(m_srdy),
        .address(m_addr), .chipselect(m_cs), .read(m_rd), .write(m_wr), .writedata(m_wdata),
        .byteenable(m_be), .waitrequest(m_wait), .readdata(m_rdata), .readdatavalid(m_rdv),
        .clear_start(m_clr), .busy(m_busy), .overflow(m_ovf));

    hist_accum_ram #(.DATA_W(8), .BIN_W(6), .SATURATE(1)) u_sat8 (
        .clk(clk), .reset(reset), .sample_valid(n_sv), .sample_bin(n_sbin), .sample_ready(s_srdy),
        .address(n_addr), .chipselect(n_cs), .read(n_rd), .write(n_wr), .writedata(n_wdata),
        .byteenable(n_be), .waitrequest(s_wait), .readdata(s_rdata), .readdatavalid(s_rdv),
        .clear_start(n_clr), .busy(s_busy), .overflow(s_ovf));

    hist_accum_ram #(.DATA_W(8), .BIN_W(6), .SATURATE(0)) u_wrap8 (
        .clk(clk), .reset(reset), .sample_valid(n_sv), .sample_bin(n_sbin), .sample_ready(w_srdy),
        .address(n_addr), .chipselect(n_cs), .read(n_rd), .write(n_wr), .writedata(n_wdata),
        .byteenable(n_be), .waitrequest(w_wait), .readdata(w_rdata), .readdatavalid(w_rdv),
        .clear_start(n_clr), .busy(w_busy), .overflow(w_ovf));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_checks++;
        n_fails++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // Monitor: pops one expectation per readdatavalid on each instance.
    always @(negedge clk) begin
        exp_t e;
        if (m_rdv) begin
            if (q_m.size() == 0) timeout_fail("main_spurious_readdatavalid");
            else begin e = q_m.pop_front(); check(e.nm, m_rdata, e.val); end
        end
        if (s_rdv) begin
            if (q_s.size() == 0) timeout_fail("sat8_spurious_readdatavalid");
            else begin e = q_s.pop_front(); check(e.nm, 32'(s_rdata), e.val); end
        end
        if (w_rdv) begin
            if (q_w.size() == 0) timeout_fail("wrap8_spurious_readdatavalid");
            else begin e = q_w.pop_front(); check(e.nm, 32'(w_rdata), e.val); end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic m_sample(input logic [5:0] bin);
        int n = 0;
        m_sv = 1'b1; m_sbin = bin;
        @(negedge clk);
        while (!m_srdy && n < 200) begin @(negedge clk); n++; end
        if (!m_srdy) timeout_fail("m_sample_ready");
        tick();
        m_sv = 1'b0;
    endtask

    task automatic m_read(input logic [5:0] addr, input logic [31:0] expv, input string nm);
        int n = 0;
        exp_t e;
        m_cs = 1'b1; m_rd = 1'b1; m_addr = addr;
        @(negedge clk);
        while (m_wait && n < 200) begin @(negedge clk); n++; end
        if (m_wait) timeout_fail("m_read_waitrequest");
        e.val = expv; e.nm = nm;
        q_m.push_back(e);
        tick();
        m_cs = 1'b0; m_rd = 1'b0;
    endtask

    task automatic m_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] be, output int stalls);
        m_cs = 1'b1; m_wr = 1'b1; m_addr = addr; m_wdata = data; m_be = be;
        stalls = 0;
        @(negedge clk);
        check("m_write_sample_ready_low", 32'(m_srdy), 32'd0);
        while (m_wait && stalls < 200) begin @(negedge clk); stalls++; end
        if (m_wait) timeout_fail("m_write_waitrequest");
        tick();
        m_cs = 1'b0; m_wr = 1'b0;
    endtask

    task automatic n_sample(input logic [5:0] bin);
        int n = 0;
        n_sv = 1'b1; n_sbin = bin;
        @(negedge clk);
        while (!s_srdy && n < 200) begin @(negedge clk); n++; end
        if (!s_srdy) timeout_fail("n_sample_ready");
        tick();
        n_sv = 1'b0;
    endtask

    task automatic n_read(input logic [5:0] addr, input logic [7:0] exp_s,
                          input logic [7:0] exp_w, input string nm);
        int n = 0;
        exp_t e;
        n_cs = 1'b1; n_rd = 1'b1; n_addr = addr;
        @(negedge clk);
        while (s_wait && n < 200) begin @(negedge clk); n++; end
        if (s_wait) timeout_fail("n_read_waitrequest");
        e.val = 32'(exp_s); e.nm = {nm, "_sat"};
        q_s.push_back(e);
        e.val = 32'(exp_w); e.nm = {nm, "_wrap"};
        q_w.push_back(e);
        tick();
        n_cs = 1'b0; n_rd = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int cnt;
        int stalls;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values, then busy for exactly DEPTH cycles.
        @(negedge clk);
        check("rst_sample_ready", 32'(m_srdy), 32'd0);
        check("rst_busy", 32'(m_busy), 32'd1);
        check("rst_waitrequest", 32'(m_wait), 32'd1);
        check("rst_readdatavalid", 32'(m_rdv), 32'd0);
        check("rst_readdata", m_rdata, 32'd0);
        check("rst_overflow", 32'(m_ovf), 32'd0);
        cnt = 0;
        while (m_busy && cnt < 1000) begin cnt++; @(negedge clk); end
        check("rst_busy_cycles", 32'(cnt), 32'(DEPTH));
        tick();
        for (int i = 0; i < int'(DEPTH); i++) m_read(6'(i), 32'd0, $sformatf("rst_bin%0d", i));
        check("rst_overflow_after_clear", 32'(m_ovf), 32'd0);

        // Same-bin forwarding and interleaving.
        for (int i = 0; i < 10; i++) m_sample(6'd5);
        m_sample(6'd6); m_sample(6'd5); m_sample(6'd6); m_sample(6'd5); m_sample(6'd6);
        m_read(6'd5, 32'd12, "fwd_bin5");
        m_read(6'd6, 32'd3, "fwd_bin6");
        m_read(6'd4, 32'd0, "fwd_bin4_untouched");

        // Byte-enabled host writes; second write stalls behind an S1 increment.
        m_write(6'd3, 32'hFFFF_FFFF, 4'hF, stalls);
        check("wr_idle_stalls", 32'(stalls), 32'd0);
        m_write(6'd3, 32'h1234_5678, 4'b0011, stalls);
        m_read(6'd3, 32'hFFFF_5678, "wr_be_bin3");
        m_sample(6'd7);
        m_write(6'd7, 32'h0000_00AA, 4'b0001, stalls);
        check("wr_after_s1_stalls", 32'(stalls), 32'd1);
        m_read(6'd7, 32'h0000_00AA, "wr_after_s1_bin7");

        // Host read in the cycle S1 takes bin 9 from 4 to 5.
        for (int i = 0; i < 5; i++) m_sample(6'd9);
        m_read(6'd9, 32'd5, "rd_during_s1_bin9");
        m_read(6'd9, 32'd5, "rd_after_s1_bin9");
        check("main_overflow_clear", 32'(m_ovf), 32'd0);

        // Clear while sampling continuously; a second clear_start is ignored.
        fork
            begin
                for (int i = 0; i < 20; i++) begin m_sv = 1'b1; m_sbin = 6'(i % 8); tick(); end
                m_sv = 1'b0;
            end
            begin
                repeat (5) tick();
                m_clr = 1'b1;
                tick();
                m_clr = 1'b0;
                cnt = 0;
                @(negedge clk);
                check("clr_sample_ready_drop", 32'(m_srdy), 32'd0);
                while (m_busy && cnt < 1000) begin
                    cnt++;
                    m_clr = (cnt == 10);
                    @(negedge clk);
                end
                m_clr = 1'b0;
                check("clr_busy_cycles", 32'(cnt), 32'(DEPTH + 2));
            end
        join
        tick();
        for (int i = 0; i < int'(DEPTH); i++) m_read(6'(i), 32'd0, $sformatf("clr_bin%0d", i));
        check("clr_overflow", 32'(m_ovf), 32'd0);

        // 8-bit counters: saturate vs wrap.
        for (int i = 0; i < 257; i++) n_sample(6'd1);
        n_read(6'd1, 8'd255, 8'd1, "n257_bin1");
        check("n257_sat_overflow", 32'(s_ovf), 32'd1);
        check("n257_wrap_overflow", 32'(w_ovf), 32'd1);
        for (int i = 0; i < 43; i++) n_sample(6'd1);
        n_read(6'd1, 8'd255, 8'd44, "n300_bin1");
        n_read(6'd0, 8'd0, 8'd0, "n300_bin0");

        // Clear engine also drops the sticky overflow.
        n_clr = 1'b1;
        tick();
        n_clr = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (s_busy && cnt < 1000) begin cnt++; @(negedge clk); end
        if (s_busy) timeout_fail("n_clear_busy");
        check("nclr_sat_overflow", 32'(s_ovf), 32'd0);
        check("nclr_wrap_overflow", 32'(w_ovf), 32'd0);
        tick();
        n_read(6'd1, 8'd0, 8'd0, "nclr_bin1");

        cnt = 0;
        while ((q_m.size() + q_s.size() + q_w.size()) != 0 && cnt < 20) begin @(negedge clk); cnt++; end
        if ((q_m.size() + q_s.size() + q_w.size()) != 0) timeout_fail("scoreboard_drain");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
